// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: one-entry pipeline register decoding RV32I instructions into ALU controls
module alu_ctrl_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_control,
  output logic        alu_src_imm,
  output logic        branch,
  output logic        branch_inv,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);
  logic [6:0] op, f7;
  logic [2:0] f3, f3_alu, d_alu;
  logic       d_imm, d_br, d_inv, d_ill, f7z, accept;
  assign op       = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign f7z      = f7 == 7'd0;
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  // funct3 to ALU op for register/immediate arithmetic (f3 011 is rejected separately)
  always_comb begin
    f3_alu = 3'b000;
    case (f3)
      3'b001: f3_alu = 3'b111;
      3'b010: f3_alu = 3'b101;
      3'b100: f3_alu = 3'b100;
      3'b101: f3_alu = 3'b110;
      3'b110: f3_alu = 3'b011;
      3'b111: f3_alu = 3'b010;
      default: f3_alu = 3'b000;
    endcase
  end
  // opcode decode; illegal entries force every control field to zero
  always_comb begin
    d_alu = 3'b000;
    d_imm = 1'b0;
    d_br  = 1'b0;
    d_inv = 1'b0;
    d_ill = 1'b0;
    case (op)
      7'b0110011: begin
        d_ill = !((f7z && f3 != 3'b011) || (f7 == 7'b0100000 && f3 == 3'b000));
        d_alu = instr[30] ? 3'b001 : f3_alu;
      end
      7'b0010011: begin
        d_ill = f3 == 3'b011 || ((f3 == 3'b001 || f3 == 3'b101) && !f7z);
        d_alu = f3_alu;
        d_imm = 1'b1;
      end
      7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111: d_imm = 1'b1;
      7'b1100111: begin
        d_ill = f3 != 3'b000;
        d_imm = 1'b1;
      end
      7'b1100011: begin
        d_ill = f3[1];
        d_br  = 1'b1;
        d_inv = f3[0];
        d_alu = f3[2] ? 3'b101 : 3'b001;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) {d_alu, d_imm, d_br, d_inv} = '0;
  end
  // stage register: flush beats accept, accept beats consume, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_control <= 3'b000;
      alu_src_imm <= 1'b0;
      branch      <= 1'b0;
      branch_inv  <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= 8'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_control <= d_alu;
      alu_src_imm <= d_imm;
      branch      <= d_br;
      branch_inv  <= d_inv;
      illegal     <= d_ill;
      illegal_cnt <= illegal_cnt + {7'd0, d_ill && illegal_cnt != 8'hff};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: scoreboard bench for alu_ctrl_stage with directed and random traffic
module tb_alu_ctrl_stage;
  logic        clk = 0, rst_n = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] instr = 0;
  logic        in_ready, out_valid, alu_src_imm, branch, branch_inv, illegal;
  logic [2:0]  alu_control;
  logic [7:0]  illegal_cnt;
  typedef struct packed {logic ill; logic [2:0] alu; logic imm, br, inv;} dec_t;
  typedef struct packed {dec_t d; logic [7:0] cnt;} ent_t;
  ent_t q[$];
  int checks = 0, fails = 0;
  logic mv = 0;
  logic [7:0] mcnt = 0;
  logic [2:0] fmap [8] = '{3'd0, 3'd7, 3'd5, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};
  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h7b};

  alu_ctrl_stage dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .branch(branch),
    .branch_inv(branch_inv), .illegal(illegal), .illegal_cnt(illegal_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic dec_t dec(input logic [31:0] i);
    logic [6:0] o = i[6:0], f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    dec_t d = '{ill: 1'b1, alu: 3'd0, imm: 1'b0, br: 1'b0, inv: 1'b0};
    if (o == 7'h33 && f7 == 7'h00 && f3 != 3'd3) d = '{1'b0, fmap[f3], 1'b0, 1'b0, 1'b0};
    else if (o == 7'h33 && f7 == 7'h20 && f3 == 3'd0) d = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    else if (o == 7'h13 && f3 != 3'd3 && (f7 == 7'h00 || (f3 != 3'd1 && f3 != 3'd5)))
      d = '{1'b0, fmap[f3], 1'b1, 1'b0, 1'b0};
    else if (o == 7'h03 || o == 7'h23 || o == 7'h37 || o == 7'h17 || o == 7'h6f || (o == 7'h67 && f3 == 3'd0))
      d = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    else if (o == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) d = '{1'b0, 3'd1, 1'b0, 1'b1, f3 == 3'd1};
    else if (o == 7'h63 && (f3 == 3'd4 || f3 == 3'd5)) d = '{1'b0, 3'd5, 1'b0, 1'b1, f3 == 3'd5};
    return d;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    ent_t e;
    logic acc;
    in_valid = v; instr = ins; out_ready = rdy; flush = fl;
    acc = v && !fl && (!mv || rdy);
    @(posedge clk);
    if (acc) begin
      e.d = dec(ins);
      if (e.d.ill && mcnt != 8'hff) mcnt++;
      e.cnt = mcnt;
      q.push_back(e);
    end
    mv = fl ? 1'b0 : acc ? 1'b1 : rdy ? 1'b0 : mv;
    #1;
    chk("out_valid", out_valid, mv);
    chk("illegal_cnt", illegal_cnt, mcnt);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom();
    logic [6:0] f7 = r[31] ? 7'h00 : r[30] ? 7'h20 : r[6:0];
    return {f7, r[24:15], r[14:12], r[11:7], ops[$urandom_range(9)]};
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("in_ready", in_ready, q.size() == 0 || out_ready);
    chk("valid_vs_queue", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("alu_control", alu_control, q[0].d.alu);
      chk("alu_src_imm", alu_src_imm, q[0].d.imm);
      chk("branch", branch, q[0].d.br);
      chk("branch_inv", branch_inv, q[0].d.inv);
      chk("illegal", illegal, q[0].d.ill);
      chk("held_cnt", illegal_cnt, q[0].cnt);
      if (out_ready || flush) void'(q.pop_front());
    end
  end

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_alu", alu_control, 0);
    chk("rst_imm", alu_src_imm, 0);
    chk("rst_br", branch, 0);
    chk("rst_inv", branch_inv, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    cyc(1, 32'h40208033, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h00209463, 1, 0);
    cyc(1, 32'h0020D463, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h00500093, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h0020B033, 1, 1);
    cyc(1, 32'h0020B033, 1, 0);
    cyc(0, 0, 1, 0);
    repeat (260) cyc(1, 32'h0020B033, 1, 0);
    cyc(0, 0, 1, 0);
    chk("cnt_saturated", illegal_cnt, 8'd255);
    repeat (3) cyc(1, 32'h0020B033, 1, 0);
    chk("cnt_holds", illegal_cnt, 8'd255);
    repeat (3000) cyc($urandom_range(3) != 0, rnd_instr(), $urandom_range(3) != 0, $urandom_range(15) == 0);
    cyc(1, 32'h0020B033, 0, 0);
    cyc(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", illegal_cnt, 0);
    chk("midrst_ill", illegal, 0);
    chk("midrst_alu", alu_control, 0);
    q.delete();
    mv = 0;
    mcnt = 0;
    #3 rst_n = 1;
    cyc(1, 32'h40208033, 1, 0);
    cyc(0, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents instr
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  RV32I instruction word
- flush  in  1  discard held entry (branch redirect)
- out_valid  out  1  registered entry valid toward execute
- out_ready  in  1  execute consumes entry
- alu_control  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SRL, 111 SLL
- alu_src_imm  out  1  1 = ALU operand B from immediate
- branch  out  1  entry is a conditional branch
- branch_inv  out  1  branch taken when zero=0 (BNE) or when SLT result=0 (BGE)
- illegal  out  1  instr unsupported by this ALU
- illegal_cnt  out  8  saturating count of accepted illegal instrs

Function
REQ-002 in_ready SHALL be combinational: !out_valid | out_ready.
REQ-003 Accept SHALL occur when in_valid & in_ready at a rising clk edge: decoded fields registered, out_valid=1 next cycle; latency exactly 1 cycle.
REQ-004 When out_valid & out_ready and no accept, out_valid SHALL clear; back-to-back accept+consume SHALL sustain 1 instr/cycle.
REQ-005 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-006 flush SHALL clear out_valid next edge and SHALL take priority over a same-cycle accept: the incoming instr is dropped and illegal_cnt is not incremented.
REQ-007 The decode SHALL use opcode=instr[6:0], f3=instr[14:12], f7b5=instr[30].
REQ-008 Opcode 0110011 (R): f3 000 -> f7b5 ? SUB : ADD; 001 SLL; 010 SLT; 100 XOR; 101 SRL if f7b5=0; 110 OR; 111 AND; alu_src_imm=0.
REQ-009 Opcode 0010011 (I): as R except f3 000 -> ADD regardless of f7b5; 001/101 require instr[31:25]=0; alu_src_imm=1.
REQ-010 Opcodes 0000011, 0100011, 0110111, 0010111, 1101111 and 1100111 with f3=000 SHALL decode to ADD with alu_src_imm=1.
REQ-011 Opcode 1100011: f3 000 -> SUB, branch_inv=0; 001 -> SUB, branch_inv=1; 100 -> SLT, branch_inv=0; 101 -> SLT, branch_inv=1; branch=1, alu_src_imm=0.
REQ-012 These SHALL be illegal=1 with alu_control=000, branch=0, alu_src_imm=0: SLTU/SLTIU (f3 011), SRA/SRAI, BLTU/BGEU, branch f3 010/011, nonzero funct7 on R ops other than SUB/SRA, any other opcode.
REQ-013 illegal_cnt SHALL increment by 1 on each accepted illegal entry and saturate at 255.
REQ-014 The branch and branch_inv outputs SHALL be 0 for all non-branch entries.

Reset
REQ-015 When rst_n=0, the block SHALL immediately drive out_valid=0, alu_control=000, alu_src_imm=0, branch=0, branch_inv=0, illegal=0, illegal_cnt=0, independent of clk.
REQ-016 Reset asserted mid-stall SHALL discard the held entry; the first accept is possible on the first edge after rst_n rises.

Verification
REQ-017 The bench SHALL cover: accept 0x40208033 (SUB) with out_ready=1 -> next cycle out_valid=1, alu_control=001, alu_src_imm=0, in_ready=1.
REQ-018 The bench SHALL cover: 0x00209463 (BNE) -> alu_control=001, branch=1, branch_inv=1; 0x0020D463 (BGE) -> alu_control=101, branch_inv=1.
REQ-019 The bench SHALL cover: out_ready=0 with entry ADDI 0x00500093 held 3 cycles -> in_ready=0, outputs stable (000, alu_src_imm=1); out_ready=1 then consumes.
REQ-020 The bench SHALL cover: flush with in_valid=1 and SLTU 0x0020B033 -> out_valid=0 next cycle, illegal_cnt unchanged; same instr without flush -> illegal=1, illegal_cnt+1.
REQ-021 The bench SHALL cover: 260 accepted illegal instrs -> illegal_cnt=255 and holds.
REQ-022 The bench SHALL cover: rst_n low between edges while stalled -> out_valid=0, illegal_cnt=0 immediately.
